frog_game_ctrl: RTL and testbench

// Consumer of the frog position box. Each frame it tests the frog box against N_HAZ hazard boxes and the

---
 rtl/frog_pkg.sv | 24 ++
 rtl/box_overlap.sv | 18 +
 rtl/frog_game_ctrl.sv | 135 +++++++++++++
 tb/tb_frog_game_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared types and constants for the frog game controller: state encoding,
// screen limits, coordinate widths and the frog start box.
package frog_pkg;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    localparam int unsigned SCREEN_H_MAX = 640;
    localparam int unsigned SCREEN_V_MAX = 480;

    // Frog start box as placed by the frog mover while pseudo is low
    localparam int unsigned START_L = 310;
    localparam int unsigned START_R = 330;
    localparam int unsigned START_T = 415;
    localparam int unsigned START_B = 435;

    typedef logic [1:0] state_t;

    localparam state_t ST_RESPAWN = 2'd0;
    localparam state_t ST_PLAY    = 2'd1;
    localparam state_t ST_HIT     = 2'd2;
    localparam state_t ST_OVER    = 2'd3;

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned box intersection; boxes that only share an edge do not overlap.
module box_overlap
    import frog_pkg::*;
(
    input  logic [X_W-1:0] a_l,
    input  logic [X_W-1:0] a_r,
    input  logic [Y_W-1:0] a_t,
    input  logic [Y_W-1:0] a_b,
    input  logic [X_W-1:0] b_l,
    input  logic [X_W-1:0] b_r,
    input  logic [Y_W-1:0] b_t,
    input  logic [Y_W-1:0] b_b,
    output logic           overlap_c
);

    assign overlap_c = (a_l < b_r) && (a_r > b_l) && (a_t < b_b) && (a_b > b_t);

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game controller: per-frame collision/goal detection, lives, score and
// the active-low respawn strobe returned to the frog mover.
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int unsigned N_HAZ        = 4,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned DEATH_FRAMES = 30,
    parameter int unsigned GOAL_Y       = 40,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned H_MAX        = SCREEN_H_MAX,
    parameter int unsigned V_MAX        = SCREEN_V_MAX
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   frame_tick,
    input  logic                   start_btn,
    input  logic [X_W-1:0]         frogL,
    input  logic [X_W-1:0]         frogR,
    input  logic [Y_W-1:0]         frogT,
    input  logic [Y_W-1:0]         frogB,
    input  logic [N_HAZ*X_W-1:0]   haz_l,
    input  logic [N_HAZ*X_W-1:0]   haz_r,
    input  logic [N_HAZ*Y_W-1:0]   haz_t,
    input  logic [N_HAZ*Y_W-1:0]   haz_b,
    output logic                   pseudo,
    output logic [1:0]             lives,
    output logic [SCORE_W-1:0]     score,
    output logic                   dying,
    output logic                   game_over
);

    localparam int unsigned CNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    logic [N_HAZ-1:0] overlap_c;
    logic             oob_c;
    logic             hit_c;
    logic             goal_c;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   death_cnt, death_cnt_nxt;
    logic [1:0]         lives_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic               pseudo_nxt, dying_nxt, game_over_nxt;

    for (genvar i = 0; i < N_HAZ; i++) begin : g_haz
        box_overlap u_overlap (
            .a_l       (frogL),
            .a_r       (frogR),
            .a_t       (frogT),
            .a_b       (frogB),
            .b_l       (haz_l[X_W*i +: X_W]),
            .b_r       (haz_r[X_W*i +: X_W]),
            .b_t       (haz_t[Y_W*i +: Y_W]),
            .b_b       (haz_b[Y_W*i +: Y_W]),
            .overlap_c (overlap_c[i])
        );
    end

    // Out-of-bounds also traps a frog mover that wrapped below zero
    assign oob_c  = (frogR > X_W'(H_MAX)) || (frogB > Y_W'(V_MAX));
    assign hit_c  = (|overlap_c) || oob_c;
    assign goal_c = (frogT <= Y_W'(GOAL_Y));

    always_comb begin
        state_nxt     = state;
        death_cnt_nxt = death_cnt;
        lives_nxt     = lives;
        score_nxt     = score;
        dying_nxt     = dying;
        game_over_nxt = game_over;

        case (state)
            ST_RESPAWN: state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (frame_tick && hit_c) begin
                    state_nxt     = ST_HIT;
                    lives_nxt     = lives - 2'd1;
                    death_cnt_nxt = CNT_W'(DEATH_FRAMES - 1);
                    dying_nxt     = 1'b1;
                end else if (frame_tick && goal_c) begin
                    state_nxt = ST_RESPAWN;
                    score_nxt = (&score) ? score : score + SCORE_W'(1);
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (death_cnt == '0) begin
                        dying_nxt = 1'b0;
                        if (lives == 2'd0) begin
                            state_nxt     = ST_OVER;
                            game_over_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_RESPAWN;
                        end
                    end else begin
                        death_cnt_nxt = death_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                if (start_btn) begin
                    state_nxt     = ST_RESPAWN;
                    lives_nxt     = 2'(LIVES_INIT);
                    score_nxt     = '0;
                    game_over_nxt = 1'b0;
                end
            end
        endcase

        // Frog mover is released only while the frog is alive on screen
        pseudo_nxt = (state_nxt == ST_PLAY) || (state_nxt == ST_HIT);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state     <= ST_RESPAWN;
            death_cnt <= '0;
            pseudo    <= 1'b0;
            lives     <= 2'(LIVES_INIT);
            score     <= '0;
            dying     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            death_cnt <= death_cnt_nxt;
            pseudo    <= pseudo_nxt;
            lives     <= lives_nxt;
            score     <= score_nxt;
            dying     <= dying_nxt;
            game_over <= game_over_nxt;
        end
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: directed scenarios followed by random
// frames, all compared against a frame-level behavioural model of the game.
module tb_frog_game_ctrl;

    localparam int N_HAZ        = 4;
    localparam int LIVES_INIT   = 3;
    localparam int DEATH_FRAMES = 30;
    localparam int GOAL_Y       = 40;
    localparam int SCORE_MAX    = 255;
    localparam int H_MAX        = 640;
    localparam int V_MAX        = 480;

    logic        clk_in;
    logic        reset_in;
    logic        frame_tick;
    logic        start_btn;
    logic [9:0]  frogL, frogR;
    logic [8:0]  frogT, frogB;
    logic [39:0] haz_l, haz_r;
    logic [35:0] haz_t, haz_b;
    logic        pseudo;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        dying;
    logic        game_over;

    frog_game_ctrl dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .frogL      (frogL),
        .frogR      (frogR),
        .frogT      (frogT),
        .frogB      (frogB),
        .haz_l      (haz_l),
        .haz_r      (haz_r),
        .haz_t      (haz_t),
        .haz_b      (haz_b),
        .pseudo     (pseudo),
        .lives      (lives),
        .score      (score),
        .dying      (dying),
        .game_over  (game_over)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Model: what the player sees, tracked frame by frame
    typedef enum {M_RESPAWN, M_PLAY, M_DYING, M_OVER} mphase_t;
    mphase_t m_phase;
    int      m_lives;
    int      m_score;
    int      m_left;

    int hl[N_HAZ], hr[N_HAZ], ht[N_HAZ], hb[N_HAZ];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pseudo"},    32'(pseudo),    32'(m_phase == M_PLAY || m_phase == M_DYING));
        chk({tag, ".lives"},     32'(lives),     32'(m_lives));
        chk({tag, ".score"},     32'(score),     32'(m_score));
        chk({tag, ".dying"},     32'(dying),     32'(m_phase == M_DYING));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_phase == M_OVER));
    endtask

    function automatic bit model_hit();
        bit h;
        h = (int'(frogR) > H_MAX) || (int'(frogB) > V_MAX);
        for (int i = 0; i < N_HAZ; i++)
            if (int'(frogL) < hr[i] && int'(frogR) > hl[i] &&
                int'(frogT) < hb[i] && int'(frogB) > ht[i])
                h = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        m_phase = M_RESPAWN;
        m_lives = LIVES_INIT;
        m_score = 0;
        m_left  = 0;
    endtask

    task automatic model_step();
        case (m_phase)
            M_RESPAWN: m_phase = M_PLAY;
            M_PLAY: if (frame_tick) begin
                if (model_hit()) begin
                    m_lives = m_lives - 1;
                    m_left  = DEATH_FRAMES;
                    m_phase = M_DYING;
                end else if (int'(frogT) <= GOAL_Y) begin
                    if (m_score < SCORE_MAX) m_score = m_score + 1;
                    m_phase = M_RESPAWN;
                end
            end
            M_DYING: if (frame_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_lives == 0) m_phase = M_OVER;
                    else              m_phase = M_RESPAWN;
                end
            end
            M_OVER: if (start_btn) begin
                m_lives = LIVES_INIT;
                m_score = 0;
                m_phase = M_RESPAWN;
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk_in);
        #1;
        check_all(tag);
    endtask

    task automatic tick_frame(input string tag);
        frame_tick = 1'b1;
        cycle(tag);
        frame_tick = 1'b0;
        cycle(tag);
    endtask

    task automatic set_frog(input int l, input int r, input int t, input int b);
        frogL = 10'(l);
        frogR = 10'(r);
        frogT = 9'(t);
        frogB = 9'(b);
    endtask

    task automatic set_haz(input int i, input int l, input int r, input int t, input int b);
        hl[i] = l; hr[i] = r; ht[i] = t; hb[i] = b;
        haz_l[10*i +: 10] = 10'(l);
        haz_r[10*i +: 10] = 10'(r);
        haz_t[9*i +: 9]   = 9'(t);
        haz_b[9*i +: 9]   = 9'(b);
    endtask

    task automatic park_haz();
        for (int i = 0; i < N_HAZ; i++) set_haz(i, 0, 10, 100, 110);
    endtask

    initial begin
        reset_in   = 1'b0;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        set_frog(310, 330, 415, 435);
        park_haz();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_all("reset");

        // Release: one clk of pseudo low already elapsed, then PLAY
        reset_in = 1'b1;
        cycle("release");
        cycle("play_idle");

        // Hit from start position, full death period, respawn
        set_haz(0, 300, 340, 410, 440);
        tick_frame("hit1");
        park_haz();
        for (int k = 0; k < DEATH_FRAMES; k++) tick_frame("death1");

        // Goal without overlap
        set_frog(310, 330, 32, 52);
        tick_frame("goal");

        // Goal with overlap in the same frame: hit wins
        set_haz(0, 300, 340, 20, 60);
        tick_frame("goal_hit");
        park_haz();
        set_frog(310, 330, 415, 435);
        for (int k = 0; k < DEATH_FRAMES; k++) tick_frame("death2");

        // Edge contact on either side is not a hit
        set_haz(0, 300, 340, 410, 440);
        set_frog(340, 360, 415, 435);
        tick_frame("edge_r");
        set_frog(280, 300, 415, 435);
        tick_frame("edge_l");
        park_haz();

        // Wrapped coordinates trip the bounds check: last life
        set_frog(1018, 1020, 415, 435);
        tick_frame("oob");
        set_frog(310, 330, 415, 435);
        for (int k = 0; k < DEATH_FRAMES; k++) tick_frame("death3");

        // Game over: frozen under further hits, then restart
        set_haz(1, 300, 340, 410, 440);
        tick_frame("over_frozen");
        start_btn = 1'b1;
        cycle("restart");
        start_btn = 1'b0;
        park_haz();
        cycle("restart_play");

        // Score saturation
        set_frog(310, 330, 32, 52);
        for (int k = 0; k < SCORE_MAX + 2; k++) tick_frame("score_sat");

        // Asynchronous reset in the middle of a death period
        set_frog(310, 330, 415, 435);
        set_haz(2, 300, 340, 410, 440);
        tick_frame("pre_reset_hit");
        park_haz();
        repeat (5) tick_frame("pre_reset_dying");
        #2;
        reset_in = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #1;
        reset_in = 1'b1;
        cycle("reset_release2");

        // Random frames
        for (int k = 0; k < 400; k++) begin
            int fl, ft;
            for (int i = 0; i < N_HAZ; i++) begin
                int l, t;
                l = int'($urandom_range(0, 600));
                t = int'($urandom_range(0, 440));
                if ($urandom_range(0, 1) == 0)
                    set_haz(i, l, l + int'($urandom_range(1, 80)), t, t + int'($urandom_range(1, 60)));
                else
                    set_haz(i, 0, 10, 100, 110);
            end
            fl = int'($urandom_range(0, 650));
            ft = int'($urandom_range(0, 470));
            set_frog(fl, fl + 20, ft, ft + 20);
            frame_tick = ($urandom_range(0, 1) == 0);
            start_btn  = ($urandom_range(0, 9) == 0);
            cycle("random");
        end
        frame_tick = 1'b0;
        start_btn  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
